pixel_write_responder: RTL and testbench
========================================

Name: pixel_write_responder

Overview:
- Memory-mapped write responder (slave end) for the Julia pixel write master's write_address/write_data/write_enable/wait_request interface.
- Accepts pixel writes, range-checks them and converts byte addresses to frame-buffer word addresses.
- Buffers accepted writes in a small FIFO and drains them to a frame-buffer RAM port with a ready handshake.
- Counts completed pixels per frame and pulses frame_done at frame end.

Parameters:
- FIFO_DEPTH, 4: entries in the write FIFO; must be a power of 2 and at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of frame-buffer word 0; must be 4-byte aligned.
- FRAME_PIXELS, 307200: number of pixels (words) in one frame.
- FB_ADDR_W, 19: frame-buffer word-address width; 2^FB_ADDR_W must be at least FRAME_PIXELS.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- n_rst  in  1  asynchronous active-low reset.
- write_address  in  32  byte address from the write master.
- write_data  in  32  pixel data from the write master.
- write_enable  in  1  master write request.
- wait_request  out  1  stall to the master; a write is accepted only when this is 0.
- fb_addr  out  FB_ADDR_W  frame-buffer word address (FIFO head).
- fb_data  out  32  frame-buffer write data (FIFO head).
- fb_we  out  1  frame-buffer write valid.
- fb_ready  in  1  frame buffer consumes the fb_* word this cycle.
- pixel_count  out  32  pixels completed in the current frame.
- frame_done  out  1  one-cycle pulse on the last pixel of a frame.
- addr_error  out  1  sticky flag: an out-of-range write was received.

Behaviour:
- Reset: FIFO empty, wait_request=1, fb_we=0, fb_addr=0, fb_data=0, pixel_count=0, frame_done=0, addr_error=0.
- Reset start-up: an init flop sets on the first clk after n_rst deasserts. wait_request = ~init | fifo_full.
- wait_request timing: driven from registers only; no combinational path from write_enable or write_address.
- Accept rule: a write is accepted when write_enable=1 and wait_request=0 in the same cycle.
- Range check: in range if BASE_ADDR <= write_address < BASE_ADDR + 4*FRAME_PIXELS, and write_address[1:0]==0.
- In-range accepted write: pushes word address (write_address-BASE_ADDR)>>2 (truncated to FB_ADDR_W) and write_data.
- Out-of-range or misaligned accepted write: consumed (not stalled), discarded, sets addr_error. addr_error clears only on reset.
- Duplicate suppression: the master holds write_enable for an extra cycle after a transfer.
  - Compare each accepted write with the previous accepted write, using the raw incoming write_address and write_data.
  - If the previous cycle was also an accept with identical write_address and write_data, the write is not pushed and not counted as an error.
  - Any cycle without an accept breaks the chain.
- Drain side:
  - fb_we = FIFO non-empty; fb_addr and fb_data show the head entry.
  - Pop when fb_we & fb_ready.
  - fb_* must stay stable while fb_we=1 and fb_ready=0.
- Simultaneous push and pop: allowed whenever the FIFO is not full; occupancy is unchanged. No push is possible when full, because wait_request=1.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits. Full when MSBs differ and the low bits are equal; wrap-around is natural.
- Push latency: a write accepted in cycle N can appear on fb_we in cycle N+1 at the earliest (registered FIFO).
- Pixel counting: on each pop, pixel_count increments.
  - If the pre-increment value is FRAME_PIXELS-1, pixel_count wraps to 0 and frame_done=1 for exactly one cycle (registered, the cycle after the pop).
- Reset mid-operation: all queued entries are dropped and outputs return to reset values immediately (asynchronous).

Test Plan:
- Reset release: n_rst low 3 cycles, then high -> wait_request=1 in the first cycle, 0 from the next cycle. fb_we=0 and pixel_count=0 throughout.
- Single write, master-style double enable:
  - Stimulus: write_address=BASE_ADDR+0x10, write_data=0xDEADBEEF, write_enable high 2 cycles, fb_ready=1.
  - Response: exactly one fb_we pulse with fb_addr=4 and fb_data=0xDEADBEEF; pixel_count=1.
- Backpressure: fb_ready=0, 6 distinct in-range writes.
  - wait_request=1 after 4 accepts; 5th and 6th stall.
  - fb_ready=1 -> all 6 pixels drain in order; count 6; no loss or duplication.
- Out of range: write_address=BASE_ADDR+4*FRAME_PIXELS -> accepted without stall, no fb_we, addr_error=1 and stays 1 across later valid writes.
- Misaligned: write_address=BASE_ADDR+0x2 -> discarded, addr_error=1.
- Frame wrap: FRAME_PIXELS=8, 9 distinct writes, fb_ready=1.
  - frame_done pulses once, after the 8th pop; pixel_count reads 0, then 1 after the 9th.
- Reset mid-drain: 3 queued entries, fb_ready=0, assert n_rst -> fb_we=0 and FIFO empty. After release, no stale entries emerge.

Source files
------------

// File: rtl/pixel_write_responder.sv
// Slave end of the pixel write bus: range-checks writes, drops the master's repeated
// transfer, queues words for the frame buffer and counts pixels per frame.
module pixel_write_responder #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned FRAME_PIXELS = 307200,
  parameter int unsigned FB_ADDR_W    = 19
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [31:0]          write_address,
  input  logic [31:0]          write_data,
  input  logic                 write_enable,
  output logic                 wait_request,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [31:0]          fb_data,
  output logic                 fb_we,
  input  logic                 fb_ready,
  output logic [31:0]          pixel_count,
  output logic                 frame_done,
  output logic                 addr_error
);

  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [32:0] END_ADDR   = {1'b0, BASE_ADDR} + (33'(FRAME_PIXELS) << 2);
  localparam logic [31:0] LAST_PIXEL = 32'(FRAME_PIXELS - 1);

  logic                 init;
  logic [PTR_W:0]       wr_ptr;
  logic [PTR_W:0]       rd_ptr;
  logic [FB_ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [31:0]          mem_data [FIFO_DEPTH];
  logic                 prev_acc;
  logic [31:0]          prev_address;
  logic [31:0]          prev_data;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 accept;
  logic                 dup;
  logic                 in_range;
  logic                 push;
  logic                 pop;
  logic [FB_ADDR_W-1:0] word_addr;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // Registered-only stall path keeps the master's timing clean.
  assign wait_request = ~init | fifo_full;
  assign accept       = write_enable & ~wait_request;

  // The master repeats a transfer for one extra cycle; identical back-to-back accepts collapse.
  assign dup = prev_acc & (write_address == prev_address) & (write_data == prev_data);

  assign in_range = ({1'b0, write_address} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, write_address} <  END_ADDR) &&
                    (write_address[1:0] == 2'b00);

  assign word_addr = FB_ADDR_W'((write_address - BASE_ADDR) >> 2);
  assign push      = accept & ~dup & in_range;
  assign pop       = ~fifo_empty & fb_ready;

  assign fb_we   = ~fifo_empty;
  assign fb_addr = fifo_empty ? '0 : mem_addr[rd_ptr[PTR_W-1:0]];
  assign fb_data = fifo_empty ? '0 : mem_data[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr[PTR_W-1:0]] <= word_addr;
      mem_data[wr_ptr[PTR_W-1:0]] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      init         <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      prev_acc     <= 1'b0;
      prev_address <= '0;
      prev_data    <= '0;
      pixel_count  <= '0;
      frame_done   <= 1'b0;
      addr_error   <= 1'b0;
    end else begin
      init       <= 1'b1;
      frame_done <= 1'b0;
      prev_acc   <= accept;
      if (accept) begin
        prev_address <= write_address;
        prev_data    <= write_data;
      end
      if (accept && !dup && !in_range) addr_error <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (pixel_count == LAST_PIXEL) begin
          pixel_count <= '0;
          frame_done  <= 1'b1;
        end else begin
          pixel_count <= pixel_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_write_responder.sv
// Randomised and directed bench for pixel_write_responder with a queue-based reference
// model and a separate frame-buffer monitor that checks words in order.
module tb_pixel_write_responder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          FP    = 8;
  localparam int          AW    = 19;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [31:0]   write_address;
  logic [31:0]   write_data;
  logic          write_enable;
  logic          wait_request;
  logic [AW-1:0] fb_addr;
  logic [31:0]   fb_data;
  logic          fb_we;
  logic          fb_ready;
  logic [31:0]   pixel_count;
  logic          frame_done;
  logic          addr_error;

  pixel_write_responder #(
    .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .FRAME_PIXELS(FP), .FB_ADDR_W(AW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .write_address(write_address), .write_data(write_data),
    .write_enable(write_enable), .wait_request(wait_request), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready), .pixel_count(pixel_count),
    .frame_done(frame_done), .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint addr;
    longint data;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     mon_pops = 0;
  int     done_seen = 0;
  bit     rand_mode = 0;

  // model state
  bit     m_init = 0;
  int     occ = 0;
  longint pops = 0;
  bit     done_exp = 0;
  bit     err_exp = 0;
  bit     prev_acc = 0;
  longint prev_a = 0;
  longint prev_d = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: occupancy, error flag and pixel count from the written rules.
  always @(negedge clk) begin
    if (!n_rst) begin
      chk("rst_wait_request", wait_request, 1);
      chk("rst_fb_we", fb_we, 0);
      chk("rst_fb_addr", fb_addr, 0);
      chk("rst_fb_data", fb_data, 0);
      chk("rst_pixel_count", pixel_count, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_addr_error", addr_error, 0);
      m_init = 0; occ = 0; pops = 0; done_exp = 0; err_exp = 0; prev_acc = 0;
      exp_q.delete();
    end else begin
      bit acc, dup, pop, inr;
      longint a, d;
      chk("wait_request", wait_request, (!m_init || occ == DEPTH) ? 1 : 0);
      chk("fb_we", fb_we, (occ > 0) ? 1 : 0);
      chk("pixel_count", pixel_count, pops % FP);
      chk("frame_done", frame_done, done_exp);
      chk("addr_error", addr_error, err_exp);
      if (frame_done) done_seen++;
      a   = longint'(write_address);
      d   = longint'(write_data);
      pop = fb_ready && occ > 0;
      acc = write_enable && m_init && occ < DEPTH;
      dup = acc && prev_acc && a == prev_a && d == prev_d;
      prev_acc = acc;
      if (acc) begin prev_a = a; prev_d = d; end
      inr = a >= longint'(BASE) && a < longint'(BASE) + 4 * FP && a % 4 == 0;
      if (acc && !dup) begin
        if (inr) begin
          exp_q.push_back('{addr: ((a - longint'(BASE)) / 4) % (64'd1 << AW), data: d});
          occ++;
        end else begin
          err_exp = 1;
        end
      end
      done_exp = 0;
      if (pop) begin
        occ--;
        pops++;
        done_exp = (pops % FP == 0);
      end
      m_init = 1;
    end
  end

  // Monitor: every presented fb word must equal the oldest expected one, and stay put until taken.
  always @(negedge clk) begin
    if (n_rst && fb_we) begin
      if (exp_q.size() == 0) begin
        chk("fb_unexpected_word", fb_we, 0);
      end else begin
        chk("fb_addr", fb_addr, exp_q[0].addr);
        chk("fb_data", fb_data, exp_q[0].data);
        if (fb_ready) begin
          void'(exp_q.pop_front());
          mon_pops++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) fb_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input bit hold2);
    bit accepted = 0;
    int n = 0;
    write_address = a;
    write_data    = d;
    write_enable  = 1'b1;
    while (!accepted && n < 200) begin
      @(negedge clk);
      if (!wait_request) accepted = 1;
      step();
      n++;
    end
    chk("write_accept_timeout", accepted, 1);
    if (hold2) step();
    write_enable = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    step();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    step();
    step();
    n_rst = 1'b1;
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [31:0] la, ld;
    n_rst = 1'b0; write_address = '0; write_data = '0; write_enable = 1'b0; fb_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk); chk("release_first_wait", wait_request, 1);
    @(negedge clk); chk("release_second_wait", wait_request, 0);
    step();

    // single write held for two cycles
    fb_ready = 1'b1;
    p0 = mon_pops;
    write(BASE + 32'h10, 32'hDEAD_BEEF, 1);
    repeat (4) step();
    chk("single_pop_count", mon_pops - p0, 1);
    @(negedge clk); chk("single_pixel_count", pixel_count, 1);
    step();

    // backpressure: four fill the FIFO, fifth stalls
    fb_ready = 1'b0;
    p0 = mon_pops;
    for (int i = 0; i < 4; i++) write(BASE + 32'(4 * i), 32'hA0 + 32'(i), 0);
    write_address = BASE + 32'h10; write_data = 32'hA4; write_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("bp_stall", wait_request, 1);
      step();
    end
    fb_ready = 1'b1;
    write(BASE + 32'h10, 32'hA4, 0);
    write(BASE + 32'h14, 32'hA5, 0);
    drain();
    chk("bp_pop_count", mon_pops - p0, 6);

    // out of range: one past the frame, then a valid write keeps the flag
    write(BASE + 32'(4 * FP), 32'h1111_1111, 1);
    step();
    @(negedge clk); chk("oor_addr_error", addr_error, 1);
    step();
    write(BASE + 32'h8, 32'h2222_2222, 1);
    drain();
    @(negedge clk); chk("oor_sticky", addr_error, 1);
    step();

    // misaligned
    do_reset();
    write(BASE + 32'h2, 32'h3333_3333, 1);
    step();
    @(negedge clk); chk("misaligned_addr_error", addr_error, 1);
    step();

    // frame wrap
    do_reset();
    done_seen = 0;
    fb_ready = 1'b1;
    for (int i = 0; i < 9; i++) write(BASE + 32'(4 * (i % FP)), 32'hF000 + 32'(i), 1);
    drain();
    repeat (3) step();
    chk("frame_done_pulses", done_seen, 1);
    @(negedge clk); chk("frame_pixel_count", pixel_count, 1);
    step();

    // reset while entries are queued
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) write(BASE + 32'(4 * i), 32'hC0 + 32'(i), 0);
    step();
    n_rst = 1'b0;
    #2 chk("rst_async_fb_we", fb_we, 0);
    step();
    step();
    n_rst = 1'b1;
    p0 = mon_pops;
    fb_ready = 1'b1;
    repeat (6) step();
    chk("stale_entries", mon_pops - p0, 0);

    // randomised traffic
    rand_mode = 1;
    la = BASE; ld = 32'h0;
    for (int i = 0; i < 250; i++) begin
      int r;
      logic [31:0] a, d;
      r = int'($urandom_range(0, 11));
      d = $urandom;
      case (r)
        0:       a = BASE - 32'd4;
        1:       a = BASE + 32'(4 * FP);
        2:       a = BASE + 32'(4 * $urandom_range(0, FP - 1)) + 32'($urandom_range(1, 3));
        default: a = BASE + 32'(4 * $urandom_range(0, FP - 1));
      endcase
      if (r == 11) begin
        // same transfer again after a gap must be written twice
        step();
        write(la, ld, 0);
      end else begin
        write(a, d, 1'($urandom_range(0, 1)));
        la = a; ld = d;
      end
      repeat ($urandom_range(0, 2)) step();
    end
    rand_mode = 0;
    fb_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
